// File: rtl/sent_pkg.sv
// sent_pkg: shared SENT TX state type, timing constants and CRC-4 helpers.
// No ports. Imported by sent_tx_crc4 and sent_tx_pulse_gen.
package sent_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_STATUS,
      ST_DATA,
      ST_CRC
`ifdef SENT_TX_PAUSE_EN
      ,
      ST_PAUSE
`endif
   } sent_state_t;

   localparam int SENT_LOW_TICKS   = 5;
   localparam int SENT_SYNC_TICKS  = 56;
   localparam int SENT_NIBBLE_BASE = 12;
   localparam int SENT_FRAME_TICKS = 282;

   localparam logic [3:0] SENT_CRC_SEED = 4'b0101;

   // Precomputed step table for x^4+x^3+x^2+1
   localparam logic [3:0] CRC4_T [16] = '{
      4'd0,  4'd13, 4'd7,  4'd10,
      4'd14, 4'd3,  4'd9,  4'd4,
      4'd1,  4'd12, 4'd6,  4'd11,
      4'd15, 4'd2,  4'd8,  4'd5
   };

   // Pulse length in ticks for a nibble value
   function automatic logic [8:0] nib_len(input logic [3:0] nib);
      return 9'(SENT_NIBBLE_BASE) + {5'd0, nib};
   endfunction

   // CRC over the first n nibbles of a left-aligned 24-bit vector,
   // MS nibble first, followed by one zero-augmentation step
   function automatic logic [3:0] crc4_nibbles(
      input logic [23:0] nibs,
      input int          n
   );
      logic [3:0] c;
      c = SENT_CRC_SEED;
      for (int i = 0; i < 6; i++) begin
         if (i < n) c = CRC4_T[c] ^ nibs[23-4*i -: 4];
      end
      return CRC4_T[c];
   endfunction

endpackage

// File: rtl/sent_tx_crc4.sv
// sent_tx_crc4: combinational SENT CRC-4 over NUM_DATA data nibbles.
// Ports: nibs (4*NUM_DATA, MS nibble first) in, crc (4) out.
module sent_tx_crc4
   import sent_pkg::*;
#(
   parameter int NUM_DATA = 6
) (
   input  logic [4*NUM_DATA-1:0] nibs,
   output logic [3:0]            crc
);

   logic [23:0] nibs_al;

   // Left-align so the helper always walks from bit 23 down
   assign nibs_al = 24'(nibs) << (24 - 4*NUM_DATA);
   assign crc     = crc4_nibbles(nibs_al, NUM_DATA);

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// sent_tx_pulse_gen: SENT (SAE J2716) transmit pulse encoder, one frame per
// valid/ready handshake; emits sync, status, data, CRC and optional pause.
// Ports: clk_tx, reset_n_tx (async, active low), ticks (unit-tick square
// wave), frame_valid/frame_ready, status_nib[3:0], data_nibs[4*NUM_DATA-1:0],
// sent_out (idle high), busy, frame_done (1-clk pulse at end of frame).
// Build option: define SENT_TX_PAUSE_EN for a constant FRAME_TICKS period.
module sent_tx_pulse_gen
   import sent_pkg::*;
#(
   parameter int NUM_DATA   = 6,
   parameter int LOW_TICKS  = SENT_LOW_TICKS,
   parameter int SYNC_TICKS = SENT_SYNC_TICKS
`ifdef SENT_TX_PAUSE_EN
   ,
   parameter int FRAME_TICKS = SENT_FRAME_TICKS
`endif
) (
   input  logic                  clk_tx,
   input  logic                  reset_n_tx,
   input  logic                  ticks,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic [3:0]            status_nib,
   input  logic [4*NUM_DATA-1:0] data_nibs,
   output logic                  sent_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam logic [2:0] LAST_DI = 3'(NUM_DATA - 1);

   sent_state_t           state;
   logic                  ticks_q;
   logic                  tick_en;
   logic [8:0]            cnt;
   logic [8:0]            len;
   logic [3:0]            status_q;
   logic [3:0]            crc_q;
   logic [3:0]            crc_w;
   logic [4*NUM_DATA-1:0] data_q;
   logic [2:0]            di;
   logic                  last_tick;
`ifdef SENT_TX_PAUSE_EN
   logic [8:0]            acc;
`endif

   sent_tx_crc4 #(
      .NUM_DATA(NUM_DATA)
   ) u_crc (
      .nibs(data_nibs),
      .crc (crc_w)
   );

   assign tick_en = ticks & ~ticks_q;

   // Length of the pulse currently being emitted; data_q is shifted
   // so its top nibble is always the current data nibble
   always_comb begin
      len = 9'(SYNC_TICKS);
      unique case (state)
         ST_STATUS: len = nib_len(status_q);
         ST_DATA:   len = nib_len(data_q[4*NUM_DATA-1 -: 4]);
         ST_CRC:    len = nib_len(crc_q);
         default:   len = 9'(SYNC_TICKS);
      endcase
   end

`ifdef SENT_TX_PAUSE_EN
   // Pause runs until the frame-wide tick total is reached
   assign last_tick = (state == ST_PAUSE) ?
                      (acc == 9'(FRAME_TICKS - 1)) :
                      (cnt == len - 9'd1);
`else
   assign last_tick = (cnt == len - 9'd1);
`endif

   // cnt is the index of the tick to be emitted on the next tick_en
   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) begin
         state       <= ST_IDLE;
         ticks_q     <= 1'b0;
         cnt         <= '0;
         status_q    <= '0;
         crc_q       <= '0;
         data_q      <= '0;
         di          <= '0;
         sent_out    <= 1'b1;
         busy        <= 1'b0;
         frame_ready <= 1'b0;
         frame_done  <= 1'b0;
`ifdef SENT_TX_PAUSE_EN
         acc         <= '0;
`endif
      end else begin
         ticks_q    <= ticks;
         frame_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               frame_ready <= 1'b1;
               if (frame_valid && frame_ready) begin
                  status_q    <= status_nib;
                  data_q      <= data_nibs;
                  crc_q       <= crc_w;
                  cnt         <= '0;
                  di          <= '0;
                  busy        <= 1'b1;
                  frame_ready <= 1'b0;
                  state       <= ST_SYNC;
`ifdef SENT_TX_PAUSE_EN
                  acc         <= '0;
`endif
               end
            end
            default: begin
               if (tick_en) begin
                  sent_out <= (cnt >= 9'(LOW_TICKS));
`ifdef SENT_TX_PAUSE_EN
                  acc      <= acc + 9'd1;
`endif
                  if (last_tick) begin
                     cnt <= '0;
                     unique case (state)
                        ST_SYNC:   state <= ST_STATUS;
                        ST_STATUS: state <= ST_DATA;
                        ST_DATA: begin
                           data_q <= data_q << 4;
                           if (di == LAST_DI) state <= ST_CRC;
                           else               di    <= di + 3'd1;
                        end
`ifdef SENT_TX_PAUSE_EN
                        ST_CRC:    state <= ST_PAUSE;
`endif
                        default: begin
                           state       <= ST_IDLE;
                           busy        <= 1'b0;
                           frame_done  <= 1'b1;
                           frame_ready <= 1'b1;
                        end
                     endcase
                  end else begin
                     cnt <= cnt + 9'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
